// File: rtl/rs15_9_encoder_pkg.sv
// Shared constants, types and GF(16) helper for the RS(15,9) encoder.
package rs_pkg;

    localparam int unsigned SYM_W = 4;
    localparam int unsigned N     = 15;
    localparam int unsigned K     = 9;
    localparam int unsigned NPAR  = 6;
    localparam int unsigned MSG_W = K * SYM_W;
    localparam int unsigned CW_W  = N * SYM_W;
    localparam int unsigned CNT_W = 4;

    // x^4 + x + 1
    localparam logic [SYM_W:0] PRIM_POLY = 5'b10011;

    typedef logic [SYM_W-1:0] sym_t;

    // Generator coefficients g0..g5 (monic x^6 term implied)
    localparam sym_t G [NPAR] = '{4'hC, 4'hA, 4'hC, 4'h3, 4'h9, 4'h7};

    typedef logic [1:0] state_t;
    localparam state_t ST_IDLE  = 2'd0;
    localparam state_t ST_SHIFT = 2'd1;
    localparam state_t ST_DONE  = 2'd2;

    // Shift-and-add GF(16) multiply; reduces by the primitive polynomial.
    function automatic sym_t gf_mul(input sym_t a, input sym_t b);
        sym_t acc;
        sym_t sh;
        acc = '0;
        sh  = a;
        for (int unsigned i = 0; i < SYM_W; i++) begin
            if (b[i]) acc = acc ^ sh;
            sh = {sh[SYM_W-2:0], 1'b0} ^ (sh[SYM_W-1] ? PRIM_POLY[SYM_W-1:0] : sym_t'(0));
        end
        return acc;
    endfunction

endpackage

// File: rtl/rs15_9_encoder_if.sv
// Message/codeword bus of the RS(15,9) encoder; RS_ENC_DONE_PULSE_EN adds encode_done.
interface rs15_9_encoder_if;
    import rs_pkg::*;

    logic [MSG_W-1:0] message;
    logic             encode_message;
    logic [CW_W-1:0]  encoded_message;
    logic             encoder_busy;
`ifdef RS_ENC_DONE_PULSE_EN
    logic             encode_done;

    modport master (output message, output encode_message,
                    input encoded_message, input encoder_busy, input encode_done);
    modport slave  (input message, input encode_message,
                    output encoded_message, output encoder_busy, output encode_done);
`else
    modport master (output message, output encode_message,
                    input encoded_message, input encoder_busy);
    modport slave  (input message, input encode_message,
                    output encoded_message, output encoder_busy);
`endif

endinterface

// File: rtl/rs15_9_encoder_gf16_const_mul.sv
// Combinational GF(16) multiply of a symbol by a fixed coefficient.
module gf16_const_mul
    import rs_pkg::*;
#(
    parameter sym_t COEF = sym_t'(1)
) (
    input  sym_t sym_i,
    output sym_t prod_c
);

    assign prod_c = gf_mul(sym_i, COEF);

endmodule

// File: rtl/rs15_9_encoder.sv
// Sequential systematic RS(15,9) encoder: 6-stage LFSR, one message symbol per clock.
// Optional macro RS_ENC_DONE_PULSE_EN adds a one-cycle encode_done output.
module rs15_9_encoder
    import rs_pkg::*;
(
    input  logic               clk,
    input  logic               rst_n,
    rs15_9_encoder_if.slave    bus
);

    state_t                  state_q, state_d;
    logic [CNT_W-1:0]        cnt_q, cnt_d;
    sym_t [K-1:0]            msg_q, msg_d;
    sym_t [NPAR-1:0]         par_q, par_d;
    logic [CW_W-1:0]         cw_q, cw_d;
    logic                    busy_q, busy_d;
    logic                    trk_q;
    logic                    done_q, done_d;

    logic                    req_c;
    sym_t                    fb_c;
    sym_t                    prod_c [NPAR];
    sym_t [NPAR-1:0]         shift_c;

    assign req_c = bus.encode_message ^ trk_q;
    assign fb_c  = msg_q[cnt_q] ^ par_q[NPAR-1];

    // One constant multiplier per generator tap, plus the shifted parity chain
    for (genvar k = 0; k < NPAR; k++) begin : g_tap
        gf16_const_mul #(.COEF(G[k])) u_mul (
            .sym_i  (fb_c),
            .prod_c (prod_c[k])
        );
        if (k == 0) begin : g_first
            assign shift_c[k] = prod_c[k];
        end else begin : g_rest
            assign shift_c[k] = par_q[k-1] ^ prod_c[k];
        end
    end

    // Next-state and datapath control
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        msg_d   = msg_q;
        par_d   = par_q;
        cw_d    = cw_q;
        busy_d  = busy_q;
        done_d  = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (req_c) begin
                    msg_d   = bus.message;
                    par_d   = '0;
                    cnt_d   = CNT_W'(K - 1);
                    busy_d  = 1'b1;
                    state_d = ST_SHIFT;
                end
            end
            ST_SHIFT: begin
                par_d = shift_c;
                if (cnt_q == '0) begin
                    state_d = ST_DONE;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            ST_DONE: begin
                cw_d    = {msg_q, par_q};
                busy_d  = 1'b0;
                done_d  = 1'b1;
                state_d = ST_IDLE;
            end
            default: begin
                busy_d  = 1'b0;
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            msg_q   <= '0;
            par_q   <= '0;
            cw_q    <= '0;
            busy_q  <= 1'b0;
            trk_q   <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            msg_q   <= msg_d;
            par_q   <= par_d;
            cw_q    <= cw_d;
            busy_q  <= busy_d;
            trk_q   <= bus.encode_message;
            done_q  <= done_d;
        end
    end

    assign bus.encoded_message = cw_q;
    assign bus.encoder_busy    = busy_q;

`ifdef RS_ENC_DONE_PULSE_EN
    assign bus.encode_done = done_q;
`else
    logic unused_done;
    assign unused_done = done_q;
`endif

endmodule

// File: tb/tb_rs15_9_encoder.sv
// Bench for rs15_9_encoder: polynomial-division reference model plus per-cycle compare.
module tb_rs15_9_encoder;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    rs15_9_encoder_if bus();

    rs15_9_encoder dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    int exp_t [15];
    int log_t [16];
    int gpoly [7];

    task automatic check(input string name, input logic [59:0] got, input logic [59:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
        end
    endtask

    function automatic int gmul(input int a, input int b);
        if (a == 0 || b == 0) return 0;
        return exp_t[(log_t[a] + log_t[b]) % 15];
    endfunction

    // Codeword = message shifted up six places, parity = remainder of long division by g(x)
    function automatic logic [59:0] rs_model(input logic [35:0] m);
        int r [15];
        logic [59:0] cw;
        for (int j = 0; j < 15; j++) r[j] = 0;
        for (int j = 0; j < 9; j++) r[j+6] = int'(m[4*j +: 4]);
        for (int d = 14; d >= 6; d--) begin
            int c;
            c = r[d];
            if (c != 0)
                for (int i = 0; i <= 6; i++) r[d-6+i] = r[d-6+i] ^ gmul(c, gpoly[i]);
        end
        cw = '0;
        for (int j = 0; j < 9; j++) cw[4*(j+6) +: 4] = m[4*j +: 4];
        for (int j = 0; j < 6; j++) cw[4*j +: 4] = 4'(r[j]);
        return cw;
    endfunction

    // Cycle-level reference: request acceptance, 10-edge latency, ignored toggles while busy
    int          m_left    = 0;
    logic [59:0] m_out     = '0;
    logic [59:0] m_pending = '0;
    logic        m_done    = 1'b0;
    logic        m_trk     = 1'b0;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_left = 0;
            m_out  = '0;
            m_done = 1'b0;
            m_trk  = 1'b0;
        end else begin
            if (m_left > 0) begin
                m_left = m_left - 1;
                m_done = (m_left == 0);
                if (m_left == 0) m_out = m_pending;
            end else begin
                m_done = 1'b0;
                if (bus.encode_message != m_trk) begin
                    m_pending = rs_model(bus.message);
                    m_left    = 10;
                end
            end
            m_trk = bus.encode_message;
        end
    end

    always @(negedge clk) begin
        check("busy", 60'(bus.encoder_busy), 60'(m_left > 0));
        check("codeword", bus.encoded_message, m_out);
`ifdef RS_ENC_DONE_PULSE_EN
        check("done", 60'(bus.encode_done), 60'(m_done));
`endif
    end

    task automatic start_encode(input logic [35:0] m);
        @(negedge clk);
        #1;
        bus.message        = m;
        bus.encode_message = ~bus.encode_message;
    endtask

    initial begin
        logic [23:0] gp;
        logic [35:0] m1;
        int          bc;

        bus.message        = '0;
        bus.encode_message = 1'b0;

        exp_t[0] = 1;
        log_t[0] = 0;
        log_t[1] = 0;
        for (int i = 1; i < 15; i++) begin
            int v;
            v = exp_t[i-1] << 1;
            if ((v & 16) != 0) v = v ^ 19;
            exp_t[i] = v;
            log_t[v] = i;
        end
        for (int i = 0; i < 7; i++) gpoly[i] = 0;
        gpoly[0] = 1;
        for (int r = 1; r <= 6; r++) begin
            for (int i = r; i >= 1; i--) gpoly[i] = gpoly[i-1] ^ gmul(gpoly[i], exp_t[r]);
            gpoly[0] = gmul(gpoly[0], exp_t[r]);
        end

        // Pin the model against hand-derived values
        for (int i = 0; i < 6; i++) gp[4*i +: 4] = 4'(gpoly[i]);
        check("gen_poly", 60'(gp), 60'h793CAC);
        check("model_sym1", rs_model(36'h0000000E0), 60'h0000000E057395F);
        check("model_sym0", rs_model(36'h000000001), 60'h000000001793CAC);

        repeat (3) @(negedge clk);
        check("reset_cw", bus.encoded_message, 60'h0);
        check("reset_busy", 60'(bus.encoder_busy), 60'h0);
        #1 rst_n = 1'b1;

        start_encode(36'h0000000E0);
        repeat (12) @(negedge clk);
        check("dir_sym1", bus.encoded_message, 60'h0000000E057395F);
        check("dir_sym1_busy", 60'(bus.encoder_busy), 60'h0);

        start_encode(36'h000000001);
        repeat (12) @(negedge clk);
        check("dir_sym0", bus.encoded_message, 60'h000000001793CAC);

        start_encode(36'h0);
        bc = 0;
        repeat (14) @(negedge clk) if (bus.encoder_busy) bc++;
        check("busy_len", 60'(bc), 60'd10);
        check("dir_zero", bus.encoded_message, 60'h0);

        // Toggle and message change while busy: result from latched message only
        m1 = {$urandom, $urandom};
        start_encode(m1);
        repeat (3) @(negedge clk);
        #1;
        bus.encode_message = ~bus.encode_message;
        bus.message        = ~m1;
        repeat (14) @(negedge clk);
        check("latched_msg", bus.encoded_message, rs_model(m1));
        check("no_requeue_busy", 60'(bus.encoder_busy), 60'h0);

        // Reset mid-encode
        start_encode({$urandom, $urandom});
        repeat (5) @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("abort_busy", 60'(bus.encoder_busy), 60'h0);
        check("abort_cw", bus.encoded_message, 60'h0);
        @(negedge clk);
        #1 rst_n = 1'b1;
        repeat (14) @(negedge clk);

        // Randomized traffic, including stray toggles while busy and idle
        for (int it = 0; it < 40; it++) begin
            start_encode({$urandom, $urandom});
            repeat ($urandom_range(3, 14)) begin
                @(negedge clk);
                #1;
                if ($urandom_range(0, 4) == 0) bus.encode_message = ~bus.encode_message;
                bus.message = {$urandom, $urandom};
            end
        end
        repeat (14) @(negedge clk);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
